// File: rtl/shift_pkg.sv
// Shared constants and types for the lane-shifter output stages.
// No logic here: widths, the legal shift limit and the serializer state encoding.
// Consumers import this package so lane geometry stays consistent across stages.
package shift_pkg;

    localparam int SYM_W     = 5;    // bits per symbol
    localparam int NUM_SYM   = 10;   // symbols per word
    localparam int SHIFT_W   = 3;    // width of upstream shift amount
    localparam int IDX_W     = 4;    // wide enough to index NUM_SYM symbols
    localparam int MAX_SHIFT = 4;    // largest shift that leaves a meaningful word

    typedef enum logic {
        IDLE = 1'b0,    // no word held
        SEND = 1'b1     // word held, symbols being emitted
    } ser_state_t;

endpackage

// File: rtl/symbol_mux.sv
// Selects one SYM_W-bit lane out of a packed word of NUM_SYM lanes by index.
// Purely combinational, zero latency; out-of-range index yields zero.
// No flow control: the caller decides when the selected lane is used.
module symbol_mux #(
    parameter int SYM_W   = 5,
    parameter int NUM_SYM = 10,
    parameter int IDX_W   = 4
) (
    input  logic [SYM_W*NUM_SYM-1:0] lanes,
    input  logic [IDX_W-1:0]         sel,
    output logic [SYM_W-1:0]         sym
);

    // Scan all lanes and pass through the one whose position matches sel
    always_comb begin
        sym = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (sel == IDX_W'(i)) begin
                sym = lanes[i*SYM_W +: SYM_W];
            end
        end
    end

endmodule

// File: rtl/symbol_serializer.sv
// Streams the meaningful symbols of a shifted word out one per cycle, lowest first; drops illegal words.
// Latency: first symbol valid the cycle after the word is accepted; back-to-back words have no bubble.
// Backpressure: a symbol is held stable until sym_ready; a new word is taken only when idle or on the last handshake.
module symbol_serializer
    import shift_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W*NUM_SYM-1:0] in_data,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic                     in_ok,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic [SYM_W-1:0]         sym_data,
    output logic [IDX_W-1:0]         sym_idx,
    output logic                     sym_last,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int WORD_W = SYM_W * NUM_SYM;

    ser_state_t          state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0]    sym_data_q, sym_data_d;
    logic                sym_last_q, sym_last_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                sym_hs;
    logic                in_acc;
    logic                shift_ok;
    logic                load;
    logic                drop;
    logic [IDX_W-1:0]    idx_inc;
    logic [IDX_W-1:0]    load_cnt;
    logic [WORD_W-1:0]   mux_word;
    logic [IDX_W-1:0]    mux_sel;
    logic [SYM_W-1:0]    mux_sym;

    // Handshake and acceptance qualifiers; in_ready is held low during reset
    always_comb begin
        sym_hs   = sym_valid_q & sym_ready;
        in_ready = rst_n & ((state_q == IDLE) | (sym_hs & sym_last_q));
        in_acc   = in_valid & in_ready;
        // A shift beyond the legal range is treated exactly like a flagged-invalid word
        shift_ok = in_ok & (int'(in_shift) <= MAX_SHIFT);
        load     = in_acc & shift_ok;
        drop     = in_acc & ~shift_ok;
        idx_inc  = idx_q + IDX_W'(1);
        load_cnt = IDX_W'(NUM_SYM) - IDX_W'(in_shift);
        // Loading selects lane 0 of the incoming word; advancing selects the next held lane
        mux_word = load ? in_data : word_q;
        mux_sel  = load ? '0 : idx_inc;
    end

    symbol_mux #(
        .SYM_W   (SYM_W),
        .NUM_SYM (NUM_SYM),
        .IDX_W   (IDX_W)
    ) u_symbol_mux (
        .lanes (mux_word),
        .sel   (mux_sel),
        .sym   (mux_sym)
    );

    // Next-state: load a new word, advance through the held word, or return to idle
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sym_valid_d = sym_valid_q;
        sym_data_d  = sym_data_q;
        sym_last_d  = sym_last_q;
        drop_cnt_d  = drop_cnt_q;

        if (load) begin
            // Also covers a new word arriving on the previous word's last handshake
            state_d     = SEND;
            word_d      = in_data;
            cnt_d       = load_cnt;
            idx_d       = '0;
            sym_valid_d = 1'b1;
            sym_data_d  = mux_sym;
            sym_last_d  = (load_cnt == IDX_W'(1));
        end else if (sym_hs) begin
            if (sym_last_q) begin
                // A dropped word accepted here also ends up idle, which this branch gives
                state_d     = IDLE;
                idx_d       = '0;
                sym_valid_d = 1'b0;
                sym_data_d  = '0;
                sym_last_d  = 1'b0;
            end else begin
                idx_d       = idx_inc;
                sym_data_d  = mux_sym;
                sym_last_d  = (idx_inc == cnt_q - IDX_W'(1));
            end
        end

        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // All state and symbol outputs registered, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_last_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            sym_last_q  <= sym_last_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign sym_idx   = idx_q;
    assign sym_last  = sym_last_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer: inputs driven 1ns after posedge, outputs sampled on negedge.
// Covers reset, full and shortened words, drops with saturation, back-to-back words, stall, mid-word reset.
// Expected values are hand-derived symbol numbers and counts.
module tb_symbol_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [2:0]  in_shift;
    logic        in_ok;
    logic        sym_valid;
    logic        sym_ready;
    logic [4:0]  sym_data;
    logic [3:0]  sym_idx;
    logic        sym_last;
    logic [7:0]  drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    symbol_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_ok     (in_ok),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_data  (sym_data),
        .sym_idx   (sym_idx),
        .sym_last  (sym_last),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [49:0] mkword(input int base);
        logic [49:0] w;
        w = '0;
        for (int k = 0; k < 10; k++) w[5*k +: 5] = 5'(base + k);
        return w;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_sym(input string tag, input int data, input int idx, input bit last, input bit rdy);
        check({tag, "_valid"}, 16'(sym_valid), 16'd1);
        check({tag, "_data"},  16'(sym_data),  16'(data));
        check({tag, "_idx"},   16'(sym_idx),   16'(idx));
        check({tag, "_last"},  16'(sym_last),  16'(last));
        check({tag, "_inrdy"}, 16'(in_ready),  16'(rdy));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, 16'(sym_valid), 16'd0);
        check({tag, "_data"},  16'(sym_data),  16'd0);
        check({tag, "_last"},  16'(sym_last),  16'd0);
        check({tag, "_inrdy"}, 16'(in_ready),  16'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_ok     = 1'b1;
        sym_ready = 1'b1;

        // Reset state
        nxt(); nxt(); smp();
        check("rst_valid", 16'(sym_valid), 16'd0);
        check("rst_data",  16'(sym_data),  16'd0);
        check("rst_idx",   16'(sym_idx),   16'd0);
        check("rst_last",  16'(sym_last),  16'd0);
        check("rst_drop",  16'(drop_cnt),  16'd0);
        check("rst_inrdy", 16'(in_ready),  16'd0);
        nxt(); rst_n = 1'b1; smp();
        chk_idle("rel");

        // 1: full word, symbols 0..9, first symbol one cycle after accept
        nxt(); in_valid = 1'b1; in_data = mkword(0); in_shift = 3'd0; in_ok = 1'b1;
        smp(); check("t1_acc_inrdy", 16'(in_ready), 16'd1);
        nxt(); in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            smp(); chk_sym("t1", k, k, k == 9, k == 9);
            nxt();
        end
        smp(); chk_idle("t1_end");

        // 2: shift 4 -> six symbols 20..25
        in_valid = 1'b1; in_data = mkword(20); in_shift = 3'd4;
        nxt(); in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp(); chk_sym("t2", 20 + k, k, k == 5, k == 5);
            nxt();
        end
        smp(); chk_idle("t2_end");

        // 3: dropped words, illegal shift with in_ok=1, saturation at 255
        in_valid = 1'b1; in_data = mkword(5); in_shift = 3'd5; in_ok = 1'b0;
        nxt(); in_valid = 1'b0;
        smp(); check("t3_drop1", 16'(drop_cnt), 16'd1);
        chk_idle("t3_nosym");
        in_valid = 1'b1; in_shift = 3'd7; in_ok = 1'b1;
        nxt(); in_valid = 1'b0;
        smp(); check("t3_badshift", 16'(drop_cnt), 16'd2);
        chk_idle("t3_badshift_nosym");
        in_valid = 1'b1; in_shift = 3'd5; in_ok = 1'b0;
        for (int i = 0; i < 260; i++) begin
            nxt();
            if (i == 251) begin smp(); check("t3_254", 16'(drop_cnt), 16'd254); end
            if (i == 252) begin smp(); check("t3_255", 16'(drop_cnt), 16'd255); end
        end
        in_valid = 1'b0; in_ok = 1'b1;
        smp(); check("t3_sat", 16'(drop_cnt), 16'd255);
        chk_idle("t3_end");

        // 4: back-to-back words, second accepted on first's last handshake
        nxt(); in_valid = 1'b1; in_data = mkword(0); in_shift = 3'd4;
        nxt(); in_data = mkword(10); in_shift = 3'd2;
        for (int k = 0; k < 6; k++) begin
            smp(); chk_sym("t4a", k, k, k == 5, k == 5);
            nxt();
            if (k == 5) in_valid = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            smp(); chk_sym("t4b", 10 + k, k, k == 7, k == 7);
            nxt();
        end
        smp(); chk_idle("t4_end");

        // 5: stall three cycles at idx 4
        in_valid = 1'b1; in_data = mkword(3); in_shift = 3'd0;
        nxt(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp(); chk_sym("t5", 3 + k, k, 1'b0, 1'b0);
            nxt();
        end
        sym_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            smp(); chk_sym("t5_hold", 7, 4, 1'b0, 1'b0);
            nxt();
        end
        sym_ready = 1'b1;
        smp(); chk_sym("t5_resume4", 7, 4, 1'b0, 1'b0);
        nxt(); smp(); chk_sym("t5_idx5", 8, 5, 1'b0, 1'b0);
        repeat (4) nxt();
        smp(); chk_sym("t5_idx9", 12, 9, 1'b1, 1'b1);
        nxt(); smp(); chk_idle("t5_end");

        // 6: reset at idx 3 abandons the word and clears the drop counter
        in_valid = 1'b1; in_data = mkword(0); in_shift = 3'd0;
        nxt(); in_valid = 1'b0;
        repeat (3) nxt();
        smp(); chk_sym("t6_pre", 3, 3, 1'b0, 1'b0);
        nxt(); rst_n = 1'b0;
        smp(); check("t6_inrdy_rst", 16'(in_ready), 16'd0);
        nxt(); rst_n = 1'b1;
        smp(); chk_idle("t6_post");
        check("t6_drop", 16'(drop_cnt), 16'd0);
        check("t6_idx",  16'(sym_idx),  16'd0);
        repeat (3) nxt();
        smp(); check("t6_quiet", 16'(sym_valid), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
